eth_tx_sched: RTL
=================

# eth_tx_sched

Transmit scheduler for the webcamera Ethernet path. It shares one MII transmit engine among N frame sources: ARP/ICMP responders, the TCP control reply and the camera UDP stream. Sources are served in round-robin order, one frame at a time. The block enforces the inter-frame gap between frames and optionally aborts a frame that hangs. It sits between the protocol builders and the nibble-wide MII TX framer, all on the 25 MHz MII clock.

## Interface
- N, 3, number of requesters (2..8)
- IFG_CYCLES, 24, idle clocks after each frame (96 bit times at 4 bits per clock)
- WDOG_CYCLES, 3100, maximum clocks from tx_start to tx_done (1526-byte frame ×2 nibbles plus margin)
- clk  in  1  MII TX clock
- clr  in  1  reset, asynchronous, active-low
- req  in  N  per-source frame request; held high until done_ack
- req_len  in  16·N  frame length in bytes, source i at [16i+15:16i]; sampled at grant
- grant  out  N  one-hot, high from grant through tx_done or abort
- sel  out  3  index of the granted source
- tx_start  out  1  one-clock pulse to the TX engine
- tx_len  out  16  latched length of the granted frame
- tx_done  in  1  one-clock pulse from the TX engine at end of frame
- tx_abort  out  1  one-clock pulse that forces the TX engine to idle
- done_ack  out  N  one-clock pulse to the served source
- busy  out  1  high in any state except IDLE
- wdog_err  out  1  one-clock pulse when a frame is aborted by the watchdog
- err_cnt  out  8  saturating count of watchdog aborts

## Operation
- States: IDLE, START, WAIT, IFG.
- IDLE:
  - If req is nonzero, pick the first requester at or after ptr, wrapping.
  - Latch grant, sel and tx_len, then set ptr to sel+1 mod N.
  - If the latched length is nonzero, go to START.
  - If the latched length is 0, the frame is rejected: pulse done_ack[sel], issue no tx_start, clear grant, stay in IDLE.
- START: tx_start is high for this one clock, then go to WAIT.
- WAIT:
  - On tx_done: pulse done_ack[sel], clear grant, load the gap counter with IFG_CYCLES−1, go to IFG.
  - tx_done in any other state is ignored.
- IFG: decrement the gap counter; at 0 go to IDLE. Requests arriving during IFG stay pending.
- Only IDLE samples req. If req drops while granted, the frame still completes and done_ack still pulses.
- Reset values: all outputs 0, ptr 0, state IDLE. Reset mid-frame drops the frame with no done_ack.

## Timing
- req sampled high in IDLE at the edge ending cycle n: grant, sel and tx_len are valid in cycle n+1, and tx_start is high in cycle n+1.
- tx_done high in cycle m:
  - done_ack is high in cycle m+1.
  - IFG occupies cycles m+1 through m+IFG_CYCLES.
  - IDLE is cycle m+IFG_CYCLES+1.
  - The earliest next tx_start is cycle m+IFG_CYCLES+2.
- Zero-length rejection: done_ack one cycle after sampling. The next grant is possible two cycles after sampling.
- tx_len is stable from grant until the next grant.

## Configuration
- ETH_TX_WDOG_EN defined:
  - A watchdog counter starts at tx_start.
  - If it reaches WDOG_CYCLES in WAIT without tx_done, the block pulses tx_abort, wdog_err and done_ack[sel], increments err_cnt (saturating at 255), and goes to IFG.
  - If tx_done arrives in the same cycle as expiry, the frame counts as normal completion with no error.
- ETH_TX_WDOG_EN undefined: WAIT waits indefinitely. tx_abort, wdog_err and err_cnt are tied to 0. The ports exist in both builds.

## Structure
- Package eth_pkg holds:
  - state encoding;
  - ETH_IFG_NIBBLES = 24;
  - ETH_MAX_FRAME_BYTES = 1526;
  - ETH_MIN_FRAME_BYTES = 64;
  - default WDOG_CYCLES.
- Sub-module eth_rr_pick: combinational round-robin selector. Inputs req and ptr; outputs one-hot pick, index and a valid flag. The scheduler FSM instantiates it once.

## Test plan
- req[0] alone, len 64; tx_done at cycle 100 → grant[0] and tx_start at cycle 1, tx_len=64, done_ack[0] at 101, busy low from 125, next tx_start no earlier than 126.
- req 3'b111 from reset, all len 100 → service order 0,1,2, each tx_start exactly IFG_CYCLES+2 after the previous tx_done, three done_ack pulses.
- req[0] and req[1] held continuously → grants alternate 0,1,0,1 over 4 frames; no source is served twice in a row.
- req[2] alone, len 0 → done_ack[2] with no tx_start and no IFG; then req[2] with len 60 → tx_start two cycles after the first sample.
- Watchdog build, req[1] with tx_done never asserted → tx_abort, wdog_err and done_ack[1] at tx_start+WDOG_CYCLES, err_cnt=1. Without the macro, busy stays high indefinitely and err_cnt stays 0.
- clr low during WAIT with req 3'b011 pending → all outputs 0 immediately; after release, grant[0] first, then grant[1].

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: scheduler state
// encoding and frame/gap/watchdog sizing constants.
package eth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_IFG   = 2'd3
   } eth_tx_state_e;

   localparam int ETH_IFG_NIBBLES     = 24;
   localparam int ETH_MAX_FRAME_BYTES = 1526;
   localparam int ETH_MIN_FRAME_BYTES = 64;
   // Two nibbles per byte for the longest frame, plus margin.
   localparam int ETH_WDOG_CYCLES     = 2 * ETH_MAX_FRAME_BYTES + 48;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr,
// wrapping modulo N.
module eth_rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] pick,
   output logic [2:0]   idx,
   output logic         valid
);

   logic [3:0] cand;

   // Walk offsets from the far end so the nearest requester wins last.
   always_comb begin
      pick  = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + 4'(k);
         if (cand >= 4'(N)) begin
            cand = cand - 4'(N);
         end
         if (req[cand[2:0]]) begin
            pick            = '0;
            pick[cand[2:0]] = 1'b1;
            idx             = cand[2:0];
            valid           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin transmit scheduler sharing one MII TX engine among N sources.
// Optional frame watchdog enabled by defining ETH_TX_WDOG_EN.
module eth_tx_sched
   import eth_pkg::*;
#(
   parameter int N           = 3,
   parameter int IFG_CYCLES  = ETH_IFG_NIBBLES,
   parameter int WDOG_CYCLES = ETH_WDOG_CYCLES
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [N-1:0]    req,
   input  logic [16*N-1:0] req_len,
   output logic [N-1:0]    grant,
   output logic [2:0]      sel,
   output logic            tx_start,
   output logic [15:0]     tx_len,
   input  logic            tx_done,
   output logic            tx_abort,
   output logic [N-1:0]    done_ack,
   output logic            busy,
   output logic            wdog_err,
   output logic [7:0]      err_cnt
);

   eth_tx_state_e state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [2:0]    sel_q, sel_d;
   logic [15:0]   tx_len_q, tx_len_d;
   logic [N-1:0]  done_ack_q, done_ack_d;
   logic [15:0]   gap_q, gap_d;

   logic [N-1:0]  pick;
   logic [2:0]    pick_idx;
   logic          pick_valid;
   logic [15:0]   pick_len;

`ifdef ETH_TX_WDOG_EN
   logic [15:0]   wd_q, wd_d;
   logic          tx_abort_q, tx_abort_d;
   logic          wdog_err_q, wdog_err_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
`endif

   eth_rr_pick #(.N(N)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .pick  (pick),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign pick_len = req_len[{pick_idx, 4'b0000} +: 16];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      tx_len_d   = tx_len_q;
      done_ack_d = '0;
      gap_d      = gap_q;
`ifdef ETH_TX_WDOG_EN
      wd_d       = wd_q;
      tx_abort_d = 1'b0;
      wdog_err_d = 1'b0;
      err_cnt_d  = err_cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               sel_d    = pick_idx;
               tx_len_d = pick_len;
               ptr_d    = (pick_idx == 3'(N - 1)) ? 3'd0 : pick_idx + 3'd1;
               // Zero-length frames are acknowledged without touching the engine.
               if (pick_len != 16'd0) begin
                  grant_d = pick;
                  state_d = ST_START;
               end else begin
                  grant_d    = '0;
                  done_ack_d = pick;
               end
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
`ifdef ETH_TX_WDOG_EN
            wd_d    = 16'd1;
`endif
         end
         ST_WAIT: begin
            if (tx_done) begin
               done_ack_d = grant_q;
               grant_d    = '0;
               gap_d      = 16'(IFG_CYCLES - 1);
               state_d    = ST_IFG;
            end
`ifdef ETH_TX_WDOG_EN
            else if (wd_q == 16'(WDOG_CYCLES - 1)) begin
               done_ack_d = grant_q;
               grant_d    = '0;
               gap_d      = 16'(IFG_CYCLES - 1);
               tx_abort_d = 1'b1;
               wdog_err_d = 1'b1;
               err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
               state_d    = ST_IFG;
            end else begin
               wd_d = wd_q + 16'd1;
            end
`endif
         end
         ST_IFG: begin
            if (gap_q == 16'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         sel_q      <= '0;
         tx_len_q   <= '0;
         done_ack_q <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         tx_len_q   <= tx_len_d;
         done_ack_q <= done_ack_d;
         gap_q      <= gap_d;
      end
   end

`ifdef ETH_TX_WDOG_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wd_q       <= '0;
         tx_abort_q <= 1'b0;
         wdog_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         wd_q       <= wd_d;
         tx_abort_q <= tx_abort_d;
         wdog_err_q <= wdog_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign tx_abort = tx_abort_q;
   assign wdog_err = wdog_err_q;
   assign err_cnt  = err_cnt_q;
`else
   assign tx_abort = 1'b0;
   assign wdog_err = 1'b0;
   assign err_cnt  = 8'd0;
`endif

   assign grant    = grant_q;
   assign sel      = sel_q;
   assign tx_len   = tx_len_q;
   assign done_ack = done_ack_q;
   assign tx_start = (state_q == ST_START);
   assign busy     = (state_q != ST_IDLE);

endmodule
